// File: rtl/mem_port_arbiter_pkg.sv
// Shared LC-3b memory types and the arbiter state encoding.
// Consumed by mem_port_arbiter_if and mem_port_arbiter.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_A = 2'b01,
        BUSY_B = 2'b10
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction port, data port and physical-memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if;
    import lc3b_types::*;

    logic          mem_read_a;
    lc3b_word      mem_address_a;
    lc3b_word      mem_rdata_a;
    logic          mem_resp_a;

    logic          mem_read_b;
    logic          mem_write_b;
    lc3b_mem_wmask mem_wmask_b;
    lc3b_word      mem_address_b;
    lc3b_word      mem_wdata_b;
    lc3b_word      mem_rdata_b;
    logic          mem_resp_b;

    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_address;
    lc3b_word      pmem_wdata;
    lc3b_mem_wmask pmem_wmask;
    lc3b_word      pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  mem_read_a, mem_address_a,
        output mem_rdata_a, mem_resp_a,
        input  mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
        output mem_rdata_b, mem_resp_b,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read_a, mem_address_a,
        input  mem_rdata_a, mem_resp_a,
        output mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
        input  mem_rdata_b, mem_resp_b,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch A / data B) arbiter onto a single physical memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed B priority.
module mem_port_arbiter
    import lc3b_types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_t    state_r;
    arb_state_t    state_s;
    lc3b_word      addr_r;
    lc3b_word      wdata_r;
    lc3b_mem_wmask wmask_r;
    logic          write_r;
    logic          flush_r;
    lc3b_word      rdata_a_r;
    lc3b_word      rdata_b_r;
`ifdef ARB_ROUND_ROBIN_EN
    port_t         last_grant_r;
`endif

    logic req_a_s;
    logic req_b_s;
    logic grant_b_s;
    logic served_req_s;
    logic resp_a_s;
    logic resp_b_s;

    // Request decode, grant choice and response qualification
    always_comb begin
        req_a_s = bus.mem_read_a;
        req_b_s = bus.mem_read_b | bus.mem_write_b;
`ifdef ARB_ROUND_ROBIN_EN
        grant_b_s = req_b_s && (!req_a_s || (last_grant_r == PORT_A));
`else
        grant_b_s = req_b_s;
`endif
        if (state_r == BUSY_A) begin
            served_req_s = req_a_s;
        end else begin
            served_req_s = req_b_s;
        end
        // A requester that has let go of its request gets no response
        resp_a_s = (state_r == BUSY_A) && bus.pmem_resp && req_a_s && !flush_r;
        resp_b_s = (state_r == BUSY_B) && bus.pmem_resp && req_b_s && !flush_r;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_b_s) begin
                    state_s = BUSY_B;
                end else if (req_a_s) begin
                    state_s = BUSY_A;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_A, BUSY_B: begin
                if (bus.pmem_resp) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, grant-time transaction copy, flush flag and held read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            addr_r    <= 16'h0000;
            wdata_r   <= 16'h0000;
            wmask_r   <= 2'b00;
            write_r   <= 1'b0;
            flush_r   <= 1'b0;
            rdata_a_r <= 16'h0000;
            rdata_b_r <= 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_r <= PORT_A;
`endif
        end else begin
            state_r <= state_s;
            if (state_r == IDLE) begin
                flush_r <= 1'b0;
                if (grant_b_s) begin
                    addr_r  <= bus.mem_address_b;
                    wdata_r <= bus.mem_wdata_b;
                    wmask_r <= bus.mem_wmask_b;
                    write_r <= bus.mem_write_b;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_r <= PORT_B;
`endif
                end else if (req_a_s) begin
                    addr_r  <= bus.mem_address_a;
                    wdata_r <= 16'h0000;
                    wmask_r <= 2'b00;
                    write_r <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_r <= PORT_A;
`endif
                end
            end else if (!served_req_s) begin
                flush_r <= 1'b1;
            end
            if (resp_a_s) begin
                rdata_a_r <= bus.pmem_rdata;
            end
            if (resp_b_s) begin
                rdata_b_r <= bus.pmem_rdata;
            end
        end
    end

    assign bus.pmem_read    = (state_r != IDLE) && !write_r;
    assign bus.pmem_write   = (state_r != IDLE) && write_r;
    assign bus.pmem_address = addr_r;
    assign bus.pmem_wdata   = wdata_r;
    assign bus.pmem_wmask   = wmask_r;

    // Read data is forwarded in the response cycle and held afterwards
    assign bus.mem_resp_a  = resp_a_s;
    assign bus.mem_resp_b  = resp_b_s;
    assign bus.mem_rdata_a = resp_a_s ? bus.pmem_rdata : rdata_a_r;
    assign bus.mem_rdata_b = resp_b_s ? bus.pmem_rdata : rdata_b_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model. Honours ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;
    import lc3b_types::*;

    logic     clk;
    logic     rst_n;
    int       total = 0;
    int       bad = 0;
    int       lat_cfg = 3;
    int       stray_cnt = 0;
    lc3b_word rm [16];
    lc3b_word exp_rdata_a = 16'h0000;
    lc3b_word exp_rdata_b = 16'h0000;

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic lc3b_word init_word(int i);
        return 16'h1234 + 16'(i) * 16'h0101;
    endfunction

    function automatic lc3b_word merge(lc3b_word old_w, lc3b_word new_w, lc3b_mem_wmask m);
        lc3b_word r;
        r = old_w;
        if (m[0]) r[7:0] = new_w[7:0];
        if (m[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    // Physical memory: answers after a latency, garbage on rdata otherwise
    initial begin : pmem_model
        lc3b_word   pm [16];
        int         cnt;
        int         cur_lat;
        int         stray_seen;
        logic [3:0] idx;
        cnt = 0;
        cur_lat = 1;
        stray_seen = 0;
        for (int i = 0; i < 16; i++) pm[i] = init_word(i);
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_seen) begin
                stray_seen     = stray_cnt;
                cnt            = 0;
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = 16'hDEAD;
            end else if (bus.pmem_read || bus.pmem_write) begin
                cnt++;
                if (cnt == 1) cur_lat = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(4, 1));
                idx = bus.pmem_address[4:1];
                if (cnt == cur_lat) begin
                    if (bus.pmem_write) pm[idx] = merge(pm[idx], bus.pmem_wdata, bus.pmem_wmask);
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = pm[idx];
                end else begin
                    bus.pmem_resp  = 1'b0;
                    bus.pmem_rdata = 16'($urandom);
                end
            end else begin
                cnt            = 0;
                bus.pmem_resp  = 1'b0;
                bus.pmem_rdata = 16'($urandom);
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_read_a    = 1'b0;
        bus.mem_address_a = 16'h0000;
        bus.mem_read_b    = 1'b0;
        bus.mem_write_b   = 1'b0;
        bus.mem_wmask_b   = 2'b00;
        bus.mem_address_b = 16'h0000;
        bus.mem_wdata_b   = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata_a = 16'h0000;
        exp_rdata_b = 16'h0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        sample_edge();
        total++;
        if ({bus.pmem_read, bus.pmem_write, bus.mem_resp_a, bus.mem_resp_b} !== 4'b0000)
            begin bad++; $display("FAIL reset_strobes: got %b want 0000",
                {bus.pmem_read, bus.pmem_write, bus.mem_resp_a, bus.mem_resp_b}); end
        total++;
        if (bus.mem_rdata_a !== 16'h0000) begin bad++; $display("FAIL reset_rdata_a: got %h want 0000", bus.mem_rdata_a); end
        total++;
        if (bus.mem_rdata_b !== 16'h0000) begin bad++; $display("FAIL reset_rdata_b: got %h want 0000", bus.mem_rdata_b); end
        total++;
        if (bus.pmem_address !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", bus.pmem_address); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_a_read();
        int       nrd = 0;
        int       nresp = 0;
        int       resp_i = -1;
        lc3b_word got = 16'h0000;
        bit       addr_ok = 1'b1;
        logic     saw;
        lat_cfg = 3;
        drive_edge();
        bus.mem_read_a    = 1'b1;
        bus.mem_address_a = 16'h0040;
        for (int i = 0; i < 12; i++) begin
            sample_edge();
            saw = bus.mem_resp_a;
            if (bus.pmem_read) begin
                nrd++;
                if (bus.pmem_address !== 16'h0040 || bus.pmem_write !== 1'b0) addr_ok = 1'b0;
            end
            if (saw) begin nresp++; resp_i = i; got = bus.mem_rdata_a; end
            drive_edge();
            if (saw) bus.mem_read_a = 1'b0;
        end
        exp_rdata_a = 16'h1234;
        total++;
        if (nrd != 3) begin bad++; $display("FAIL a_read_cycles: got %0d want 3", nrd); end
        total++;
        if (nresp != 1) begin bad++; $display("FAIL a_resp_pulses: got %0d want 1", nresp); end
        total++;
        if (resp_i != 3) begin bad++; $display("FAIL a_latency: got %0d want 3", resp_i); end
        total++;
        if (got !== 16'h1234) begin bad++; $display("FAIL a_rdata: got %h want 1234", got); end
        total++;
        if (!addr_ok) begin bad++; $display("FAIL a_pmem_addr: got bad want 0040 read"); end
        sample_edge();
        total++;
        if (bus.mem_rdata_a !== 16'h1234) begin bad++; $display("FAIL a_rdata_hold: got %h want 1234", bus.mem_rdata_a); end
    endtask

    task automatic test_contention();
        int       a_first = -1, b_first = -1, a_resp_i = -1, b_resp_i = -1;
        lc3b_word a_data = 16'h0000;
        bit       wok = 1'b1;
        logic     sa, sb;
        lat_cfg = 2;
        drive_edge();
        bus.mem_read_a    = 1'b1;
        bus.mem_address_a = 16'h0010;
        bus.mem_write_b   = 1'b1;
        bus.mem_read_b    = 1'b0;
        bus.mem_address_b = 16'h0200;
        bus.mem_wdata_b   = 16'hBEEF;
        bus.mem_wmask_b   = 2'b11;
        for (int i = 0; i < 14; i++) begin
            sample_edge();
            sa = bus.mem_resp_a;
            sb = bus.mem_resp_b;
            if (bus.pmem_write && b_first < 0) b_first = i;
            if (bus.pmem_read && a_first < 0) a_first = i;
            if (bus.pmem_write && (bus.pmem_address !== 16'h0200 || bus.pmem_wdata !== 16'hBEEF
                || bus.pmem_wmask !== 2'b11)) wok = 1'b0;
            if (sb) b_resp_i = i;
            if (sa) begin a_resp_i = i; a_data = bus.mem_rdata_a; end
            drive_edge();
            if (sb) begin bus.mem_write_b = 1'b0; bus.mem_read_b = 1'b0; end
            if (sa) bus.mem_read_a = 1'b0;
        end
        rm[0] = 16'hBEEF;
        exp_rdata_a = rm[8];
        exp_rdata_b = 16'hBEEF;
        total++;
        if (b_first != 1) begin bad++; $display("FAIL cont_b_first: got %0d want 1", b_first); end
        total++;
        if (b_resp_i != 2) begin bad++; $display("FAIL cont_b_resp: got %0d want 2", b_resp_i); end
        total++;
        if (a_first != 4) begin bad++; $display("FAIL cont_a_first: got %0d want 4", a_first); end
        total++;
        if (a_resp_i != 5) begin bad++; $display("FAIL cont_a_resp: got %0d want 5", a_resp_i); end
        total++;
        if (!wok) begin bad++; $display("FAIL cont_write_fields: got mismatch want 0200/beef/11"); end
        total++;
        if (a_data !== rm[8]) begin bad++; $display("FAIL cont_a_data: got %h want %h", a_data, rm[8]); end
    endtask

    task automatic test_round_robin();
        int       served;
        int       exp_port;
        lc3b_word data;
        do_reset();
        lat_cfg = 2;
        for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_port = (r == 1) ? 1 : 2;
`else
            exp_port = 2;
`endif
            served = -1;
            data   = 16'h0000;
            drive_edge();
            bus.mem_read_a    = 1'b1;
            bus.mem_address_a = 16'h0002;
            bus.mem_read_b    = 1'b1;
            bus.mem_address_b = 16'h0004;
            for (int i = 0; i < 20 && served < 0; i++) begin
                sample_edge();
                if (bus.mem_resp_a) begin served = 1; data = bus.mem_rdata_a; end
                if (bus.mem_resp_b) begin served = 2; data = bus.mem_rdata_b; end
                drive_edge();
                if (served >= 0) idle_inputs();
            end
            idle_inputs();
            drive_edge();
            drive_edge();
            if (served == 1) exp_rdata_a = rm[1];
            if (served == 2) exp_rdata_b = rm[2];
            total++;
            if (served != exp_port) begin bad++; $display("FAIL rr_round%0d: got port %0d want %0d", r, served, exp_port); end
            total++;
            if (data !== rm[exp_port]) begin bad++; $display("FAIL rr_data%0d: got %h want %h", r, data, rm[exp_port]); end
        end
    endtask

    task automatic test_flush();
        int nrd = 0;
        int nresp = 0;
        lat_cfg = 4;
        drive_edge();
        bus.mem_read_a    = 1'b1;
        bus.mem_address_a = 16'h0004;
        for (int i = 0; i < 10; i++) begin
            sample_edge();
            if (bus.pmem_read) nrd++;
            if (bus.mem_resp_a) nresp++;
            drive_edge();
            if (i == 1) bus.mem_read_a = 1'b0;
        end
        sample_edge();
        total++;
        if (nrd != 4) begin bad++; $display("FAIL flush_read_cycles: got %0d want 4", nrd); end
        total++;
        if (nresp != 0) begin bad++; $display("FAIL flush_resp: got %0d want 0", nresp); end
        total++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0)
            begin bad++; $display("FAIL flush_idle: got %b%b want 00", bus.pmem_read, bus.pmem_write); end
        total++;
        if (bus.mem_rdata_a !== exp_rdata_a) begin bad++; $display("FAIL flush_hold: got %h want %h", bus.mem_rdata_a, exp_rdata_a); end
    endtask

    task automatic test_reset_mid();
        int viol = 0;
        lat_cfg = 8;
        drive_edge();
        bus.mem_read_b    = 1'b1;
        bus.mem_address_b = 16'h0006;
        for (int i = 0; i < 3; i++) sample_edge();
        total++;
        if (bus.pmem_read !== 1'b1) begin bad++; $display("FAIL rstmid_busy: got %b want 1", bus.pmem_read); end
        #2;
        rst_n = 1'b0;
        bus.mem_read_b = 1'b0;
        #1;
        total++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0)
            begin bad++; $display("FAIL rstmid_async: got %b%b want 00", bus.pmem_read, bus.pmem_write); end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        exp_rdata_a = 16'h0000;
        exp_rdata_b = 16'h0000;
        stray_cnt++;
        for (int i = 0; i < 6; i++) begin
            sample_edge();
            if (bus.mem_resp_b !== 1'b0 || bus.mem_resp_a !== 1'b0 || bus.pmem_read !== 1'b0
                || bus.mem_rdata_b !== 16'h0000) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL rstmid_no_resp: got %0d bad cycles want 0", viol); end
    endtask

    task automatic test_addr_change();
        int       addr_bad = 0;
        int       nresp = 0;
        lc3b_word data = 16'h0000;
        logic     saw;
        lat_cfg = 3;
        drive_edge();
        bus.mem_read_b    = 1'b1;
        bus.mem_address_b = 16'h0300;
        for (int i = 0; i < 8; i++) begin
            sample_edge();
            saw = bus.mem_resp_b;
            if (bus.pmem_read && bus.pmem_address !== 16'h0300) addr_bad++;
            if (saw) begin nresp++; data = bus.mem_rdata_b; end
            drive_edge();
            if (i == 1) bus.mem_address_b = 16'h0302;
            if (saw) bus.mem_read_b = 1'b0;
        end
        exp_rdata_b = rm[0];
        total++;
        if (addr_bad != 0) begin bad++; $display("FAIL addr_hold: got %0d bad cycles want 0", addr_bad); end
        total++;
        if (nresp != 1 || data !== rm[0]) begin bad++; $display("FAIL addr_resp: got %0d/%h want 1/%h", nresp, data, rm[0]); end
    endtask

    task automatic test_random();
        int            m_busy = 0;
        int            m_last = 1;
        int            winner;
        int            n_done = 0;
        lc3b_word      m_addr = 16'h0000, m_wdata = 16'h0000;
        lc3b_mem_wmask m_wmask = 2'b00;
        logic          m_write = 1'b0;
        logic          a_on = 1'b0, b_on = 1'b0, w;
        logic          exp_r, exp_w, saw_resp, done_a, done_b;
        logic [3:0]    idx;
        do_reset();
        lat_cfg = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            sample_edge();
            exp_r = (m_busy != 0) && !m_write;
            exp_w = (m_busy != 0) && m_write;
            total++;
            if (bus.pmem_read !== exp_r || bus.pmem_write !== exp_w)
                begin bad++; $display("FAIL rnd_strobe@%0d: got %b%b want %b%b", cyc, bus.pmem_read, bus.pmem_write, exp_r, exp_w); end
            if (m_busy != 0) begin
                total++;
                if (bus.pmem_address !== m_addr) begin bad++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, bus.pmem_address, m_addr); end
                if (m_write) begin
                    total++;
                    if (bus.pmem_wdata !== m_wdata || bus.pmem_wmask !== m_wmask)
                        begin bad++; $display("FAIL rnd_wdata@%0d: got %h/%b want %h/%b", cyc, bus.pmem_wdata, bus.pmem_wmask, m_wdata, m_wmask); end
                end
            end
            saw_resp = bus.pmem_resp;
            done_a = (m_busy == 1) && saw_resp;
            done_b = (m_busy == 2) && saw_resp;
            idx = m_addr[4:1];
            if (done_b && m_write) rm[idx] = merge(rm[idx], m_wdata, m_wmask);
            if (done_a) exp_rdata_a = rm[idx];
            if (done_b) exp_rdata_b = rm[idx];
            total++;
            if (bus.mem_resp_a !== done_a || bus.mem_resp_b !== done_b)
                begin bad++; $display("FAIL rnd_resp@%0d: got %b%b want %b%b", cyc, bus.mem_resp_a, bus.mem_resp_b, done_a, done_b); end
            total++;
            if (bus.mem_rdata_a !== exp_rdata_a || bus.mem_rdata_b !== exp_rdata_b)
                begin bad++; $display("FAIL rnd_rdata@%0d: got %h/%h want %h/%h", cyc, bus.mem_rdata_a, bus.mem_rdata_b, exp_rdata_a, exp_rdata_b); end
            if (done_a || done_b) n_done++;
            drive_edge();
            if (m_busy == 0) begin
                if (a_on || b_on) begin
                    if (a_on && b_on) begin
`ifdef ARB_ROUND_ROBIN_EN
                        winner = (m_last == 1) ? 2 : 1;
`else
                        winner = 2;
`endif
                    end else begin
                        winner = b_on ? 2 : 1;
                    end
                    if (winner == 2) begin
                        m_addr = bus.mem_address_b; m_wdata = bus.mem_wdata_b;
                        m_wmask = bus.mem_wmask_b; m_write = bus.mem_write_b;
                    end else begin
                        m_addr = bus.mem_address_a; m_write = 1'b0;
                    end
                    m_last = winner;
                    m_busy = winner;
                end
            end else if (saw_resp) begin
                m_busy = 0;
            end
            if (done_a) begin a_on = 1'b0; bus.mem_read_a = 1'b0; end
            if (done_b) begin b_on = 1'b0; bus.mem_read_b = 1'b0; bus.mem_write_b = 1'b0; end
            if (m_busy == 1) bus.mem_address_a = 16'($urandom);
            if (m_busy == 2) begin
                bus.mem_address_b = 16'($urandom);
                bus.mem_wdata_b   = 16'($urandom);
                bus.mem_wmask_b   = 2'($urandom);
            end
            if (!a_on && $urandom_range(2, 0) == 0) begin
                a_on = 1'b1;
                bus.mem_read_a    = 1'b1;
                bus.mem_address_a = 16'($urandom);
            end
            if (!b_on && $urandom_range(2, 0) == 0) begin
                b_on = 1'b1;
                w = 1'($urandom);
                bus.mem_write_b   = w;
                bus.mem_read_b    = w ? 1'($urandom) : 1'b1;
                bus.mem_address_b = 16'($urandom);
                bus.mem_wdata_b   = 16'($urandom);
                bus.mem_wmask_b   = 2'($urandom);
            end
        end
        total++;
        if (n_done < 20) begin bad++; $display("FAIL rnd_progress: got %0d responses want >=20", n_done); end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        for (int i = 0; i < 16; i++) rm[i] = init_word(i);
        test_reset();
        test_single_a_read();
        test_contention();
        test_round_robin();
        test_flush();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-002 SHALL expose these instruction-port signals:
- mem_read_a, input, 1: fetch request.
- mem_address_a, input, lc3b_word: fetch address.
- mem_rdata_a, output, lc3b_word: fetch data.
- mem_resp_a, output, 1: fetch done, 1-cycle pulse.
REQ-003 SHALL expose these data-port signals:
- mem_read_b, input, 1: load request.
- mem_write_b, input, 1: store request.
- mem_wmask_b, input, lc3b_mem_wmask: byte enables.
- mem_address_b, input, lc3b_word: data address.
- mem_wdata_b, input, lc3b_word: store data.
- mem_rdata_b, output, lc3b_word: load data.
- mem_resp_b, output, 1: done, 1-cycle pulse.
REQ-004 SHALL expose these physical-memory signals:
- pmem_read, output, 1.
- pmem_write, output, 1.
- pmem_address, output, lc3b_word.
- pmem_wdata, output, lc3b_word.
- pmem_wmask, output, lc3b_mem_wmask.
- pmem_rdata, input, lc3b_word.
- pmem_resp, input, 1: 1-cycle completion pulse.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY_A, BUSY_B; exactly one transaction outstanding at pmem.
REQ-006 In IDLE, a pending request (mem_read_a, or mem_read_b|mem_write_b) SHALL be granted at the next rising edge; the target state is BUSY_A or BUSY_B.
REQ-007 At grant, the arbiter SHALL latch address, wdata, wmask and direction; pmem_* SHALL be driven from the latched copies throughout BUSY_x, ignoring requester changes.
REQ-008 pmem_read/pmem_write SHALL be high for every cycle of BUSY_x until pmem_resp, and low in IDLE.
REQ-009 When pmem_resp is high in BUSY_x, mem_resp_x SHALL be asserted in that same cycle, with mem_rdata_x = pmem_rdata (combinational forward); the FSM SHALL return to IDLE at that edge.
REQ-010 Minimum latency from request to mem_resp_x SHALL be 1 grant cycle plus the pmem latency; back-to-back grants SHALL pass through IDLE for one cycle.
REQ-011 If both ports request in IDLE, port B SHALL win unless REQ-018 applies.
REQ-012 mem_write_b and mem_read_b both high SHALL be treated as a write.
REQ-013 If the granted requester drops its request before pmem_resp (flush), the pmem transaction SHALL still complete, and mem_resp_x SHALL be suppressed for that transaction.
REQ-014 mem_rdata_x SHALL hold its last forwarded value outside response cycles; mem_resp_x SHALL never be asserted outside BUSY_x.
REQ-015 pmem_resp arriving in IDLE SHALL be ignored.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, pmem_read = pmem_write = 0, mem_resp_a = mem_resp_b = 0, latched registers and mem_rdata_x = 0, and last_grant = A.
REQ-017 Reset mid-transaction SHALL abandon the transaction; no response is delivered for it after reset release.

Configuration
REQ-018 With ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the port not granted last (last_grant register). Without the macro, last_grant SHALL be absent and fixed B-priority per REQ-011 SHALL apply.

Structure
REQ-019 The arb_state_t enum (IDLE, BUSY_A, BUSY_B) and lc3b_mem_wmask SHALL reside in the lc3b_types package, alongside lc3b_word.
REQ-020 The design SHALL be a single flat module with no sub-module; FSM, latches and output muxing are in one file.

Verification
REQ-021 Scenario, single A read: mem_read_a=1, addr 0x0040, pmem returns 0x1234 after 3 cycles -> pmem_read high 3 cycles, mem_resp_a one pulse, mem_rdata_a = 0x1234.
REQ-022 Scenario, contention without the macro: A read 0x0010 and B write 0x0200/0xBEEF with mask 2'b11 in the same cycle -> B served first; A served after one IDLE cycle.
REQ-023 Scenario, contention with ARB_ROUND_ROBIN_EN: three consecutive simultaneous A/B requests after reset -> grants ordered B, A, B.
REQ-024 Scenario, flush: mem_read_a dropped 1 cycle after grant -> pmem_read held until pmem_resp, no mem_resp_a, FSM back to IDLE.
REQ-025 Scenario, reset: rst_n pulsed low in BUSY_B -> pmem strobes 0 asynchronously; no mem_resp_b after release, even if pmem_resp arrives later.
REQ-026 Scenario, address change: mem_address_b changed from 0x0300 to 0x0302 while in BUSY_B -> pmem_address stays 0x0300.
